// File: rtl/conv2d3x3_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv2d3x3_job_sequencer
// Brief    : Streams kernel RAM then input RAM into Conv2D3x3 AXIS ports and
//            counts conv output beats until the job completes.
// Revision : 1.0 - initial release
// ============================================================================

module conv2d3x3_stream_engine #(
  parameter int DEPTH = 18,
  parameter int DW    = 64,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          active_i,
  output logic          en_o,
  output logic [AW-1:0] addr_o,
  input  logic [DW-1:0] rdata_i,
  output logic          tvalid_o,
  input  logic          tready_i,
  output logic [DW-1:0] tdata_o,
  output logic          last_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] slot0_q, slot0_d;
  logic [DW-1:0] slot1_q, slot1_d;
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    occ_q, occ_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          issued_all_q, issued_all_d;
  logic [CW-1:0] hs_cnt_q, hs_cnt_d;
  logic          pop;
  logic          issue;

  assign pop = (occ_q != 2'd0) & tready_i;

  // The beat leaving this cycle frees its slot before the new read can land,
  // so counting it as credit keeps one beat per cycle with tready held high.
  assign issue = active_i & ~issued_all_q &
                 ((3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

  always_comb begin
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    occ_d        = occ_q;
    inflight_d   = inflight_q;
    addr_d       = addr_q;
    issued_all_d = issued_all_q;
    hs_cnt_d     = hs_cnt_q;
    if (!active_i) begin
      slot0_d      = '0;
      slot1_d      = '0;
      wptr_d       = 1'b0;
      rptr_d       = 1'b0;
      occ_d        = 2'd0;
      inflight_d   = 1'b0;
      addr_d       = '0;
      issued_all_d = 1'b0;
      hs_cnt_d     = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        if (addr_q == AW'(DEPTH - 1)) begin
          issued_all_d = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      if (inflight_q) begin
        if (wptr_q) begin
          slot1_d = rdata_i;
        end else begin
          slot0_d = rdata_i;
        end
        wptr_d = ~wptr_q;
      end
      if (pop) begin
        rptr_d   = ~rptr_q;
        hs_cnt_d = hs_cnt_q + CW'(1);
      end
      occ_d = occ_q + 2'(inflight_q) - 2'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot0_q      <= '0;
      slot1_q      <= '0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      addr_q       <= '0;
      issued_all_q <= 1'b0;
      hs_cnt_q     <= '0;
    end else begin
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      addr_q       <= addr_d;
      issued_all_q <= issued_all_d;
      hs_cnt_q     <= hs_cnt_d;
    end
  end

  assign en_o     = issue;
  assign addr_o   = addr_q;
  assign tvalid_o = (occ_q != 2'd0);
  assign tdata_o  = rptr_q ? slot1_q : slot0_q;
  assign last_o   = pop & (hs_cnt_q == CW'(DEPTH - 1));

endmodule

module conv2d3x3_job_sequencer #(
  parameter int IN_HEIGHT        = 4,
  parameter int IN_WIDTH         = 4,
  parameter int IN_CHANNEL       = 2,
  parameter int WORD_WIDTH       = 8,
  parameter int FILTERS          = 8,
  parameter int KERNEL_BUF_WIDTH = 64,
  parameter int KERNEL_DEPTH     = 9 * FILTERS * IN_CHANNEL * WORD_WIDTH / KERNEL_BUF_WIDTH,
  parameter int IN_DEPTH         = IN_HEIGHT * IN_WIDTH * IN_CHANNEL,
  parameter int OUT_BEATS        = (IN_HEIGHT - 2) * (IN_WIDTH - 2),
  localparam int KAW             = $clog2(KERNEL_DEPTH),
  localparam int IAW             = $clog2(IN_DEPTH),
  localparam int OCW             = $clog2(OUT_BEATS + 1)
) (
  input  logic                        i_aclk,
  input  logic                        i_areset,
  input  logic                        i_start,
  input  logic                        i_reuse_kernel,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_kernel_loaded,
  output logic                        o_kmem_en,
  output logic [KAW-1:0]              o_kmem_addr,
  input  logic [KERNEL_BUF_WIDTH-1:0] i_kmem_data,
  output logic                        o_imem_en,
  output logic [IAW-1:0]              o_imem_addr,
  input  logic [WORD_WIDTH-1:0]       i_imem_data,
  output logic                        o_kernel_tvalid,
  input  logic                        i_kernel_tready,
  output logic [KERNEL_BUF_WIDTH-1:0] o_kernel_tdata,
  output logic                        o_tvalid,
  input  logic                        i_tready,
  output logic [WORD_WIDTH-1:0]       o_tdata,
  input  logic                        i_out_tvalid,
  input  logic                        i_out_tready,
  output logic [OCW-1:0]              o_out_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_K = 3'd1,
    S_LOAD_I = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic           kloaded_q, kloaded_d;
  logic           k_last;
  logic           i_last;
  logic           out_hs;

  // Output beats may overlap input streaming, so both LOAD_I and DRAIN count.
  assign out_hs = i_out_tvalid & i_out_tready &
                  ((state_q == S_LOAD_I) || (state_q == S_DRAIN));

  always_comb begin
    state_d   = state_q;
    out_cnt_d = out_cnt_q;
    kloaded_d = kloaded_q | k_last;
    if (out_hs && (out_cnt_q != OCW'(OUT_BEATS))) begin
      out_cnt_d = out_cnt_q + OCW'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          out_cnt_d = '0;
          state_d   = (i_reuse_kernel && kloaded_q) ? S_LOAD_I : S_LOAD_K;
        end
      end
      S_LOAD_K: if (k_last) state_d = S_LOAD_I;
      S_LOAD_I: if (i_last) state_d = S_DRAIN;
      S_DRAIN:  if (out_cnt_d == OCW'(OUT_BEATS)) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state_q   <= S_IDLE;
      out_cnt_q <= '0;
      kloaded_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
      kloaded_q <= kloaded_d;
    end
  end

  conv2d3x3_stream_engine #(
    .DEPTH (KERNEL_DEPTH),
    .DW    (KERNEL_BUF_WIDTH),
    .AW    (KAW)
  ) u_kernel_engine (
    .clk_i    (i_aclk),
    .rst_i    (i_areset),
    .active_i (state_q == S_LOAD_K),
    .en_o     (o_kmem_en),
    .addr_o   (o_kmem_addr),
    .rdata_i  (i_kmem_data),
    .tvalid_o (o_kernel_tvalid),
    .tready_i (i_kernel_tready),
    .tdata_o  (o_kernel_tdata),
    .last_o   (k_last)
  );

  conv2d3x3_stream_engine #(
    .DEPTH (IN_DEPTH),
    .DW    (WORD_WIDTH),
    .AW    (IAW)
  ) u_input_engine (
    .clk_i    (i_aclk),
    .rst_i    (i_areset),
    .active_i (state_q == S_LOAD_I),
    .en_o     (o_imem_en),
    .addr_o   (o_imem_addr),
    .rdata_i  (i_imem_data),
    .tvalid_o (o_tvalid),
    .tready_i (i_tready),
    .tdata_o  (o_tdata),
    .last_o   (i_last)
  );

  assign o_busy          = (state_q != S_IDLE);
  assign o_done          = (state_q == S_DONE);
  assign o_kernel_loaded = kloaded_q;
  assign o_out_count     = out_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_conv2d3x3_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv2d3x3_job_sequencer
// Brief    : Self-checking bench for conv2d3x3_job_sequencer against RAM order.
// Revision : 1.0 - initial release
// ============================================================================

module tb_conv2d3x3_job_sequencer;

  localparam int KD = 18;
  localparam int ID = 32;

  logic        i_aclk = 1'b0;
  logic        i_areset;
  logic        i_start;
  logic        i_reuse_kernel;
  logic        o_busy;
  logic        o_done;
  logic        o_kernel_loaded;
  logic        o_kmem_en;
  logic [4:0]  o_kmem_addr;
  logic [63:0] i_kmem_data;
  logic        o_imem_en;
  logic [4:0]  o_imem_addr;
  logic [7:0]  i_imem_data;
  logic        o_kernel_tvalid;
  logic        i_kernel_tready;
  logic [63:0] o_kernel_tdata;
  logic        o_tvalid;
  logic        i_tready;
  logic [7:0]  o_tdata;
  logic        i_out_tvalid;
  logic        i_out_tready;
  logic [2:0]  o_out_count;

  logic [63:0] kmem [KD];
  logic [7:0]  imem [ID];

  int passed = 0;
  int total  = 0;

  conv2d3x3_job_sequencer dut (
    .i_aclk          (i_aclk),
    .i_areset        (i_areset),
    .i_start         (i_start),
    .i_reuse_kernel  (i_reuse_kernel),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_kernel_loaded (o_kernel_loaded),
    .o_kmem_en       (o_kmem_en),
    .o_kmem_addr     (o_kmem_addr),
    .i_kmem_data     (i_kmem_data),
    .o_imem_en       (o_imem_en),
    .o_imem_addr     (o_imem_addr),
    .i_imem_data     (i_imem_data),
    .o_kernel_tvalid (o_kernel_tvalid),
    .i_kernel_tready (i_kernel_tready),
    .o_kernel_tdata  (o_kernel_tdata),
    .o_tvalid        (o_tvalid),
    .i_tready        (i_tready),
    .o_tdata         (o_tdata),
    .i_out_tvalid    (i_out_tvalid),
    .i_out_tready    (i_out_tready),
    .o_out_count     (o_out_count)
  );

  always #5 i_aclk = ~i_aclk;

  // Synchronous RAMs with one cycle read latency.
  always @(posedge i_aclk) begin
    if (o_kmem_en) i_kmem_data <= kmem[o_kmem_addr];
    if (o_imem_en) i_imem_data <= imem[o_imem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_job(input bit reuse, input bit exp_k, input bit rnd,
                         input bit out_early, input int abort_at);
    int k_hs = 0, i_hs = 0, k_rd = 0, i_rd = 0, out_sent = 0, cyc = 0;
    int k_first = -1, k_last = -1, i_first = -1, i_last = -1;
    bit done_seen = 0, prev_out4 = 0, out_now;
    bit prev_k_stall = 0, prev_i_stall = 0;
    logic [63:0] prev_kd = '0;
    logic [7:0]  prev_id = '0;

    @(negedge i_aclk);
    i_start = 1'b1;
    i_reuse_kernel = reuse;
    @(negedge i_aclk);
    i_start = 1'b0;
    while (!done_seen && cyc < 600) begin
      i_kernel_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_tready        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_now = (out_early && i_hs >= 8 && out_sent < 2) || (i_hs == ID && out_sent < 4);
      i_out_tvalid = out_now;
      i_out_tready = out_now;
      #1;
      if (abort_at > 0 && i_hs == abort_at) begin
        i_areset = 1'b1;
        #1;
        chk("abort_busy", o_busy, 0);
        chk("abort_tvalid", o_tvalid, 0);
        chk("abort_imem_en", o_imem_en, 0);
        chk("abort_kloaded", o_kernel_loaded, 0);
        chk("abort_ktvalid", o_kernel_tvalid, 0);
        chk("abort_kmem_en", o_kmem_en, 0);
        @(negedge i_aclk);
        i_areset = 1'b0;
        i_out_tvalid = 1'b0;
        i_out_tready = 1'b0;
        return;
      end
      chk("busy", o_busy, 1);
      chk("done", o_done, prev_out4);
      chk("out_count", o_out_count, out_sent);
      if (o_kmem_en) begin
        chk("kmem_allowed", exp_k && k_rd < KD, 1);
        chk("kmem_addr", o_kmem_addr, k_rd);
        k_rd++;
      end
      if (o_imem_en) begin
        chk("imem_allowed", i_rd < ID, 1);
        chk("imem_addr", o_imem_addr, i_rd);
        i_rd++;
      end
      if (prev_k_stall) begin
        chk("ktvalid_hold", o_kernel_tvalid, 1);
        chk("ktdata_hold", o_kernel_tdata, prev_kd);
      end
      if (prev_i_stall) begin
        chk("tvalid_hold", o_tvalid, 1);
        chk("tdata_hold", o_tdata, prev_id);
      end
      if (o_kernel_tvalid && i_kernel_tready) begin
        chk("kbeat_in_range", k_hs < KD, 1);
        if (k_hs < KD) chk("ktdata", o_kernel_tdata, kmem[k_hs]);
        if (k_first < 0) k_first = cyc;
        k_last = cyc;
        k_hs++;
      end
      if (o_tvalid && i_tready) begin
        chk("ibeat_in_range", i_hs < ID, 1);
        if (i_hs < ID) chk("tdata", o_tdata, imem[i_hs]);
        if (i_first < 0) i_first = cyc;
        i_last = cyc;
        i_hs++;
      end
      prev_k_stall = o_kernel_tvalid && !i_kernel_tready;
      prev_kd      = o_kernel_tdata;
      prev_i_stall = o_tvalid && !i_tready;
      prev_id      = o_tdata;
      prev_out4    = out_now && out_sent == 3;
      if (out_now) out_sent++;
      done_seen = o_done;
      @(negedge i_aclk);
      cyc++;
    end
    if (!done_seen) chk("timeout_done", 0, 1);
    chk("kernel_beats", k_hs, exp_k ? KD : 0);
    chk("input_beats", i_hs, ID);
    chk("kmem_reads", k_rd, exp_k ? KD : 0);
    chk("imem_reads", i_rd, ID);
    chk("kernel_loaded", o_kernel_loaded, 1);
    if (!rnd) begin
      if (exp_k) begin
        chk("k_first_cycle", k_first, 2);
        chk("k_back_to_back", k_last - k_first, KD - 1);
      end
      chk("i_first_cycle", i_first, exp_k ? 22 : 2);
      chk("i_back_to_back", i_last - i_first, ID - 1);
    end
    i_out_tvalid = 1'b0;
    i_out_tready = 1'b0;
    #1;
    chk("idle_busy", o_busy, 0);
    chk("idle_done", o_done, 0);
    chk("idle_out_count", o_out_count, 4);
  endtask

  initial begin
    for (int k = 0; k < KD; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      kmem[k] = {8{kb}};
    end
    for (int j = 0; j < ID; j++) imem[j] = 8'($urandom_range(0, 255));
    i_areset = 1'b1;
    i_start = 1'b0;
    i_reuse_kernel = 1'b0;
    i_kernel_tready = 1'b0;
    i_tready = 1'b0;
    i_out_tvalid = 1'b0;
    i_out_tready = 1'b0;
    repeat (3) @(negedge i_aclk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_kloaded", o_kernel_loaded, 0);
    chk("rst_kmem_en", o_kmem_en, 0);
    chk("rst_kmem_addr", o_kmem_addr, 0);
    chk("rst_imem_en", o_imem_en, 0);
    chk("rst_imem_addr", o_imem_addr, 0);
    chk("rst_ktvalid", o_kernel_tvalid, 0);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_out_count", o_out_count, 0);
    i_areset = 1'b0;
    @(negedge i_aclk);
    #1;
    chk("idle_after_rst", o_busy, 0);

    run_job(1'b0, 1'b1, 1'b0, 1'b0, 0);
    run_job(1'b1, 1'b0, 1'b0, 1'b1, 0);
    run_job(1'b0, 1'b1, 1'b1, 1'b1, 0);
    run_job(1'b1, 1'b0, 1'b1, 1'b0, 0);
    run_job(1'b0, 1'b1, 1'b0, 1'b0, 5);
    run_job(1'b1, 1'b1, 1'b1, 1'b1, 0);
    run_job(1'b1, 1'b0, 1'b0, 1'b1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
